udp_av_rx: RTL and testbench
============================

# udp_av_rx

Receive-side GMII parser for the HDMI-over-Ethernet link. It accepts Ethernet/IPv4/UDP frames carrying the team's packet format: packet-ID byte, then video line and/or audio records. It filters frames by address, type and port. Video lines are unpacked into 16-bit pixel-pair writes to the line FIFO, and audio/aux bytes go to the aux FIFO. It sits directly downstream of the PHY RX pins on the sink board and mirrors the transmit framer on the source board.

## Interface
Parameters:
- `local_mac`, `{8'h00,8'h23,8'h45,8'h67,8'h89,8'h02}`: own MAC; byte 5 is compared against `local_mac[7:0] - id`.
- `udp_port`, `16'h3039`: accepted UDP destination port.
- `line_pix`, `11'd1200`: pixel bytes per video line.
- `aux_rec`, `6'd34`: bytes per aux record (2 AUXID + 32 data).

Ports (every port is synchronous to `rx_clk`):
- `rx_clk`, in, 1: GMII receive clock; the only clock.
- `sys_rst`, in, 1: synchronous, active-low reset; 0 = reset.
- `id`, in, 1: board ID, subtracted from MAC byte 5.
- `rx_dv`, in, 1: GMII data valid.
- `rx_er`, in, 1: GMII receive error.
- `rxd`, in, 8: GMII data.
- `vid_full`, in, 1: video FIFO full.
- `vid_wr_en`, out, 1: video FIFO write strobe.
- `vid_din`, out, 17: `{sol, hi_byte, lo_byte}`. `sol`=1 marks the line header word.
- `aux_full`, in, 1: aux FIFO full.
- `aux_wr_en`, out, 1: aux FIFO write strobe.
- `aux_din`, out, 9: `{sor, byte}`. `sor`=1 marks the first AUXID byte of a record.
- `frm_ok`, out, 16: count of frames fully accepted (wraps).
- `frm_drop`, out, 16: count of frames dropped after SFD (wraps).
- `ovf`, out, 1: sticky; set on any write attempted while the target FIFO is full.

## Operation
- `rx_dv`, `rx_er` and `rxd` are registered once; the FSM acts on the registered copy.
- States: IDLE, PRE, HDR, PID, RESOL, PIX, AUXID, AUX, DROP.
- IDLE: a registered 0x55 with dv=1 → PRE.
- PRE: 0x55 stays in PRE. 0xD5 → HDR with byte counter=0. Any other byte → IDLE; not counted.
- HDR covers bytes 0..41. Each check failure → DROP.
  - Bytes 0..5 must equal `local_mac` with byte 5 adjusted.
  - Bytes 12..13 = 0x0800.
  - Byte 23 = 0x11.
  - Bytes 36..37 = `udp_port`.
  - Bytes 38..39 are latched as `udp_len`. Payload length `plen = udp_len - 8` (16-bit, unsigned).
  - `plen < 1` → DROP.
  - All other bytes are ignored; checksums are not checked.
- PID: one byte.
  - 0x00 (video) → RESOL.
  - 0x02 (video+aux) → RESOL.
  - 0x01 (audio) → AUXID.
  - Any other value → DROP.
- RESOL: two bytes; write one word `{1, b0, b1}` → PIX.
- PIX: bytes are paired and `{0, first, second}` is written per pair, `line_pix/2` writes in total. After the last pair: video → end check; video+aux → AUXID.
- AUXID/AUX: every byte is written to aux. `sor`=1 on byte 0 of each `aux_rec` block. Stop at `plen` payload bytes.
- End check:
  - Payload complete and dv still 1 (FCS bytes) → ignore the remaining bytes until dv=0, then `frm_ok++` → IDLE.
  - FCS is not verified.
- DROP: wait for dv=0, then `frm_drop++` → IDLE.
- These conditions send the FSM to DROP immediately, and it writes nothing further for that frame:
  - `rx_er`=1 in any state after SFD.
  - dv falling before `plen` bytes are consumed.
  - Write attempted while full. In this case the write is suppressed and `ovf` is set.
- Words already written for a dropped frame are not retracted. Downstream resyncs on `sol`.
- A video payload shorter than 3+`line_pix` is a truncation and goes to DROP. Any extra payload bytes beyond the expected layout are ignored.

## Timing
- Reset values: all outputs 0, counters 0, `ovf`=0, state IDLE.
- Reset is sampled every cycle and overrides everything, including mid-frame. A frame in progress at reset release is ignored until dv=0 followed by a new preamble.
- A byte on `rxd` at cycle n is evaluated at cycle n+1.
- Video write latency: `vid_wr_en` is high at n+2, where n is the cycle of the second byte of the pair.
- Aux write latency: `aux_wr_en` is high at n+2 for the byte at cycle n.
- Strobes are single-cycle. Video writes are at most one per two bytes; aux writes at most one per byte.
- The full checks use `vid_full`/`aux_full` as sampled in the write cycle.
- `frm_ok`/`frm_drop` update one cycle after dv=0 is registered. Both wrap at 0xFFFF→0.
- Back-to-back frames: a preamble may start the cycle after dv falls. The FSM must be in IDLE within 2 cycles of dv falling.

## Test plan
- Video frame, `id`=0, dst byte 5=0x02, `udp_len`=1211, PID 0, resol 0x12/0x34, pixels i&0xFF → 601 video writes; first `{1,0x12,0x34}`, then `{0,0x00,0x01}`…; `frm_ok`=1; no aux writes.
- Audio frame, PID 1, two records, `udp_len`=8+1+68 → 68 aux writes, `sor` on bytes 0 and 34; `frm_ok`=1.
- Bad dst MAC (byte 5=0x03, `id`=0) → no writes; `frm_drop`=1.
- Same MAC with `id`=1, byte 5=0x01 → accepted.
- `rx_er` pulse at pixel byte 100 → writes stop at ≤50 pixel words; `frm_drop`=1; the next good frame is accepted normally.
- `vid_full` high for one cycle during PIX → that write suppressed, `ovf`=1, frame dropped. Then `sys_rst`=0 mid-frame → all outputs 0, counters 0.

Source files
------------

// File: rtl/udp_av_rx.sv
// udp_av_rx: GMII Ethernet/IPv4/UDP receive parser that unpacks video lines into
// pixel-pair words for the line FIFO and audio/aux records into bytes for the aux FIFO.
module udp_av_rx #(
  parameter logic [47:0] local_mac = {8'h00, 8'h23, 8'h45, 8'h67, 8'h89, 8'h02},
  parameter logic [15:0] udp_port = 16'h3039,
  parameter logic [10:0] line_pix = 11'd1200,
  parameter logic [5:0] aux_rec = 6'd34
) (
  input  logic        rx_clk,
  input  logic        sys_rst,
  input  logic        id,
  input  logic        rx_dv,
  input  logic        rx_er,
  input  logic [7:0]  rxd,
  input  logic        vid_full,
  output logic        vid_wr_en,
  output logic [16:0] vid_din,
  input  logic        aux_full,
  output logic        aux_wr_en,
  output logic [8:0]  aux_din,
  output logic [15:0] frm_ok,
  output logic [15:0] frm_drop,
  output logic        ovf
);
  typedef enum logic [3:0] {IDLE, PRE, HDR, PID, RESOL, PIX, AUXID, AUX, DONE, DROP} state_t;
  state_t state_q, state_d;
  logic dv_q, er_q;
  logic [7:0] d_q;
  logic [5:0] cnt_q, cnt_d, rec_q, rec_d, rec_nx, mac_off;
  logic [15:0] len_q, len_d, pcnt_q, pcnt_d, plen, ok_q, ok_d, drop_q, drop_d;
  logic [9:0] pix_q, pix_d;
  logic half_q, half_d, va_q, va_d, armed_q, armed_d, ovf_q, ovf_d;
  logic [7:0] b0_q, b0_d, mac_b;
  logic vwr_q, vwr_d, awr_q, awr_d;
  logic [16:0] vdin_q, vdin_d;
  logic [8:0] adin_q, adin_d;
  logic last, fin, wr_fail, hdr_bad;
  assign plen = len_q - 16'd8;
  assign last = pcnt_q + 16'd1 == plen;
  assign fin = half_q && pix_q == line_pix[10:1] - 10'd1;
  assign wr_fail = (vwr_q & vid_full) | (awr_q & aux_full);
  assign rec_nx = rec_q == aux_rec - 6'd1 ? 6'd0 : rec_q + 6'd1;
  assign mac_off = 6'd40 - {cnt_q[2:0], 3'b000};
  assign mac_b = cnt_q == 6'd5 ? local_mac[7:0] - {7'd0, id} : local_mac[mac_off +: 8];
  assign hdr_bad = (cnt_q < 6'd6 && d_q != mac_b) || (cnt_q == 6'd12 && d_q != 8'h08) ||
                   (cnt_q == 6'd13 && d_q != 8'h00) || (cnt_q == 6'd23 && d_q != 8'h11) ||
                   (cnt_q == 6'd36 && d_q != udp_port[15:8]) || (cnt_q == 6'd37 && d_q != udp_port[7:0]);
  assign vid_wr_en = vwr_q & ~vid_full;
  assign aux_wr_en = awr_q & ~aux_full;
  assign vid_din = vdin_q;
  assign aux_din = adin_q;
  assign frm_ok = ok_q;
  assign frm_drop = drop_q;
  assign ovf = ovf_q;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    len_d = len_q;
    pcnt_d = pcnt_q;
    pix_d = pix_q;
    half_d = half_q;
    b0_d = b0_q;
    rec_d = rec_q;
    va_d = va_q;
    armed_d = armed_q | ~dv_q;
    vwr_d = 1'b0;
    vdin_d = vdin_q;
    awr_d = 1'b0;
    adin_d = adin_q;
    ok_d = ok_q;
    drop_d = drop_q;
    ovf_d = ovf_q | wr_fail;
    case (state_q)
      IDLE: state_d = armed_q && dv_q && d_q == 8'h55 ? PRE : IDLE;
      PRE: begin
        cnt_d = '0;
        state_d = dv_q && d_q == 8'h55 ? PRE : dv_q && d_q == 8'hD5 ? HDR : IDLE;
      end
      DROP: begin
        drop_d = dv_q ? drop_q : drop_q + 16'd1;
        state_d = dv_q ? DROP : IDLE;
      end
      default: begin
        if (!dv_q) begin
          ok_d = state_q == DONE && !wr_fail ? ok_q + 16'd1 : ok_q;
          drop_d = state_q == DONE && !wr_fail ? drop_q : drop_q + 16'd1;
          state_d = IDLE;
        end else if (er_q || wr_fail) begin
          state_d = DROP;
        end else begin
          pcnt_d = state_q == HDR ? 16'd0 : pcnt_q + 16'd1;
          case (state_q)
            HDR: begin
              cnt_d = cnt_q + 6'd1;
              len_d = cnt_q == 6'd38 ? {d_q, len_q[7:0]} : cnt_q == 6'd39 ? {len_q[15:8], d_q} : len_q;
              state_d = hdr_bad ? DROP : cnt_q != 6'd41 ? HDR : plen == 16'd0 ? DROP : PID;
            end
            PID: begin
              va_d = d_q == 8'h02;
              half_d = 1'b0;
              pix_d = '0;
              rec_d = '0;
              state_d = d_q == 8'h00 || d_q == 8'h02 ? (last ? DROP : RESOL) :
                        d_q == 8'h01 ? (last ? DONE : AUXID) : DROP;
            end
            RESOL: begin
              half_d = ~half_q;
              b0_d = d_q;
              vwr_d = half_q;
              vdin_d = half_q ? {1'b1, b0_q, d_q} : vdin_q;
              state_d = last ? DROP : half_q ? PIX : RESOL;
            end
            PIX: begin
              half_d = ~half_q;
              b0_d = d_q;
              vwr_d = half_q;
              vdin_d = half_q ? {1'b0, b0_q, d_q} : vdin_q;
              pix_d = half_q ? pix_q + 10'd1 : pix_q;
              rec_d = '0;
              state_d = fin ? (va_q && !last ? AUXID : DONE) : last ? DROP : PIX;
            end
            AUXID, AUX: begin
              awr_d = 1'b1;
              adin_d = {rec_q == 6'd0, d_q};
              rec_d = rec_nx;
              state_d = last ? DONE : rec_nx < 6'd2 ? AUXID : AUX;
            end
            default: state_d = state_q;
          endcase
        end
      end
    endcase
  end
  always_ff @(posedge rx_clk) begin
    if (!sys_rst) begin
      state_q <= IDLE;
      dv_q <= 1'b0;
      er_q <= 1'b0;
      d_q <= '0;
      cnt_q <= '0;
      len_q <= '0;
      pcnt_q <= '0;
      pix_q <= '0;
      half_q <= 1'b0;
      b0_q <= '0;
      rec_q <= '0;
      va_q <= 1'b0;
      armed_q <= 1'b0;
      vwr_q <= 1'b0;
      vdin_q <= '0;
      awr_q <= 1'b0;
      adin_q <= '0;
      ok_q <= '0;
      drop_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      dv_q <= rx_dv;
      er_q <= rx_er;
      d_q <= rxd;
      cnt_q <= cnt_d;
      len_q <= len_d;
      pcnt_q <= pcnt_d;
      pix_q <= pix_d;
      half_q <= half_d;
      b0_q <= b0_d;
      rec_q <= rec_d;
      va_q <= va_d;
      armed_q <= armed_d;
      vwr_q <= vwr_d;
      vdin_q <= vdin_d;
      awr_q <= awr_d;
      adin_q <= adin_d;
      ok_q <= ok_d;
      drop_q <= drop_d;
      ovf_q <= ovf_d;
    end
  end
endmodule

// File: tb/tb_udp_av_rx.sv
// tb_udp_av_rx: scoreboard bench for udp_av_rx; expected FIFO writes are queued
// as each frame is built and popped as the DUT strobes its write enables.
module tb_udp_av_rx;
  logic rx_clk = 0, sys_rst = 0, id = 0, rx_dv = 0, rx_er = 0, vid_full = 0, aux_full = 0;
  logic [7:0] rxd = 0;
  logic vid_wr_en, aux_wr_en, ovf;
  logic [16:0] vid_din;
  logic [8:0] aux_din;
  logic [15:0] frm_ok, frm_drop;
  int n_cmp = 0, n_bad = 0, exp_ok = 0, exp_drop = 0, len_fix = -1;
  logic [15:0] port = 16'h3039;
  logic [16:0] vq[$];
  logic [8:0] aq[$];
  logic [7:0] fb[$];
  always #4 rx_clk = ~rx_clk;
  udp_av_rx dut (
    .rx_clk(rx_clk), .sys_rst(sys_rst), .id(id), .rx_dv(rx_dv), .rx_er(rx_er), .rxd(rxd),
    .vid_full(vid_full), .vid_wr_en(vid_wr_en), .vid_din(vid_din),
    .aux_full(aux_full), .aux_wr_en(aux_wr_en), .aux_din(aux_din),
    .frm_ok(frm_ok), .frm_drop(frm_drop), .ovf(ovf)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  always @(negedge rx_clk) begin
    if (vid_wr_en) begin
      if (vq.size() == 0) chk("vid_extra", {31'd0, vid_wr_en}, 32'd0);
      else chk("vid_word", {15'd0, vid_din}, {15'd0, vq.pop_front()});
    end
    if (aux_wr_en) begin
      if (aq.size() == 0) chk("aux_extra", {31'd0, aux_wr_en}, 32'd0);
      else chk("aux_byte", {23'd0, aux_din}, {23'd0, aq.pop_front()});
    end
  end
  task automatic hdr(input logic [7:0] m5, input int pbytes);
    logic [15:0] ul;
    logic [7:0] h[42];
    ul = len_fix >= 0 ? 16'(len_fix) : 16'(pbytes + 8);
    h = '{8'h00, 8'h23, 8'h45, 8'h67, 8'h89, m5, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h08, 8'h00,
          8'h45, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h40, 8'h00, 8'h40, 8'h11, 8'h00, 8'h00,
          8'hC0, 8'hA8, 8'h01, 8'h01, 8'hC0, 8'hA8, 8'h01, 8'h02,
          8'h30, 8'h39, port[15:8], port[7:0], ul[15:8], ul[7:0], 8'h00, 8'h00};
    fb.delete();
    repeat (7) fb.push_back(8'h55);
    fb.push_back(8'hD5);
    foreach (h[i]) fb.push_back(h[i]);
  endtask
  task automatic tail();
    fb.push_back(8'hA5);
    fb.push_back(8'h5A);
    fb.push_back(8'hC3);
    fb.push_back(8'h3C);
  endtask
  task automatic video(input logic [7:0] m5, input logic [7:0] pid, input int naux, input int npairs);
    hdr(m5, 3 + 1200 + naux);
    fb.push_back(pid);
    fb.push_back(8'h12);
    fb.push_back(8'h34);
    for (int i = 0; i < 1200; i++) fb.push_back(8'(i));
    for (int j = 0; j < naux; j++) fb.push_back(8'(j * 7 + 3));
    tail();
    if (npairs >= 0) vq.push_back({1'b1, 8'h12, 8'h34});
    for (int k = 0; k < npairs; k++) vq.push_back({1'b0, 8'(2 * k), 8'(2 * k + 1)});
    if (npairs == 600)
      for (int j = 0; j < naux; j++) aq.push_back({j % 34 == 0, 8'(j * 7 + 3)});
  endtask
  task automatic audio(input logic [7:0] m5, input int n, input bit exp_wr);
    hdr(m5, 1 + n);
    fb.push_back(8'h01);
    for (int j = 0; j < n; j++) fb.push_back(8'(j * 7 + 3));
    tail();
    if (exp_wr)
      for (int j = 0; j < n; j++) aq.push_back({j % 34 == 0, 8'(j * 7 + 3)});
  endtask
  task automatic send(input int er_at, input int full_at, input int rst_at);
    foreach (fb[i]) begin
      rx_dv = 1;
      rxd = fb[i];
      rx_er = i == er_at;
      vid_full = i == full_at + 2;
      sys_rst = !(rst_at >= 0 && i >= rst_at && i < rst_at + 5);
      if (rst_at >= 0 && i == rst_at + 3) begin
        chk("rst_vwr", {31'd0, vid_wr_en}, 32'd0);
        chk("rst_awr", {31'd0, aux_wr_en}, 32'd0);
        chk("rst_vdin", {15'd0, vid_din}, 32'd0);
        chk("rst_adin", {23'd0, aux_din}, 32'd0);
        chk("rst_ok", {16'd0, frm_ok}, 32'd0);
        chk("rst_drop", {16'd0, frm_drop}, 32'd0);
        chk("rst_ovf", {31'd0, ovf}, 32'd0);
      end
      @(posedge rx_clk);
      #1;
    end
    rx_dv = 0;
    rx_er = 0;
    rxd = 0;
    vid_full = 0;
    sys_rst = 1;
    repeat (12) @(posedge rx_clk);
    #1;
  endtask
  task automatic post(input string t);
    chk({t, "_ok"}, {16'd0, frm_ok}, 32'(exp_ok));
    chk({t, "_drop"}, {16'd0, frm_drop}, 32'(exp_drop));
    chk({t, "_vid_left"}, 32'(vq.size()), 32'd0);
    chk({t, "_aux_left"}, 32'(aq.size()), 32'd0);
    vq.delete();
    aq.delete();
  endtask
  initial begin
    repeat (4) @(posedge rx_clk);
    #1;
    chk("reset_vwr", {31'd0, vid_wr_en}, 32'd0);
    chk("reset_awr", {31'd0, aux_wr_en}, 32'd0);
    chk("reset_ovf", {31'd0, ovf}, 32'd0);
    post("reset");
    sys_rst = 1;
    repeat (4) @(posedge rx_clk);
    #1;
    video(8'h02, 8'h00, 0, 600); send(-1, -1, -1); exp_ok++; post("video");
    audio(8'h02, 68, 1); send(-1, -1, -1); exp_ok++; post("audio");
    audio(8'h03, 4, 0); send(-1, -1, -1); exp_drop++; post("bad_mac");
    id = 1;
    audio(8'h01, 34, 1); send(-1, -1, -1); exp_ok++; post("id1");
    id = 0;
    video(8'h02, 8'h02, 34, 600); send(-1, -1, -1); exp_ok++; post("vid_aux");
    video(8'h02, 8'h00, 0, 50); send(53 + 100, -1, -1); exp_drop++; post("rx_er");
    audio(8'h02, 10, 1); send(-1, -1, -1); exp_ok++; post("after_er");
    port = 16'h3040;
    audio(8'h02, 5, 0); send(-1, -1, -1); exp_drop++; post("bad_port");
    port = 16'h3039;
    len_fix = 8;
    audio(8'h02, 5, 0); send(-1, -1, -1); exp_drop++; post("plen0");
    len_fix = 8 + 3 + 100;
    video(8'h02, 8'h00, 0, 50); send(-1, -1, -1); exp_drop++; post("trunc");
    len_fix = -1;
    chk("ovf_before", {31'd0, ovf}, 32'd0);
    video(8'h02, 8'h00, 0, 10); send(-1, 53 + 21, -1); exp_drop++; post("full");
    chk("ovf_after", {31'd0, ovf}, 32'd1);
    video(8'h02, 8'h00, 0, -1); exp_ok = 0; exp_drop = 0; send(-1, -1, 20); post("mid_reset");
    chk("ovf_cleared", {31'd0, ovf}, 32'd0);
    video(8'h02, 8'h00, 0, 600); send(-1, -1, -1); exp_ok++; post("post_reset");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
